ps2_scancode_decoder: RTL and testbench
=======================================

# ps2_scancode_decoder

Consumes raw PS/2 Set-2 scan-code bytes from the keyboard interface receive side (byte + receive strobe). Resolves E0 (extended), F0 (break) and E1 (Pause) prefix sequences into single key events, decodes number-row digits for bet entry, and buffers events in a 4-deep FIFO. Downstream game logic pops events with a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4, event FIFO depth; power of two, at least 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received scan-code byte; sampled on the rising edge of rx_valid.
- rx_valid  in  1  receive strobe from the PS/2 interface; may be high for 1 or more cycles.
- ev_ready  in  1  consumer accepts the head event when high together with ev_valid.
- clear_ovf  in  1  one-cycle pulse; clears ovf.
- ev_valid  out  1  FIFO non-empty.
- ev_code  out  8  final scan-code byte of the head event.
- ev_ext  out  1  head event was prefixed by E0.
- ev_release  out  1  head event was prefixed by F0 (break).
- ev_is_digit  out  1  head event is a non-extended number-row digit.
- ev_digit  out  4  digit value 0-9; 0 when ev_is_digit=0.
- ovf  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- Edge detect: rx_valid is registered. A byte is taken in the cycle where rx_valid=1 and the registered rx_valid=0. A held strobe yields exactly one byte.
- Prefix FSM, states IDLE, EXT, BRK, EXT_BRK, SKIP:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip counter=7; any other byte emits an event (ext=0, rel=0) and stays in IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT (ignored); other bytes emit an event (ext=1, rel=0) -> IDLE.
  - BRK: other bytes emit an event (ext=0, rel=1) -> IDLE; E0/F0 discard the partial sequence -> IDLE.
  - EXT_BRK: other bytes emit an event (ext=1, rel=1) -> IDLE; E0/F0 -> IDLE.
  - SKIP: each byte decrements the 3-bit counter; when it reaches 0, return to IDLE. No event is emitted (the 8-byte Pause sequence is swallowed).
- Digit map (ext=0 only): 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9. All other codes give is_digit=0, digit=0.
- FIFO push happens on each event emit.
- Pop when ev_valid and ev_ready.
- Push while full with no pop in the same cycle: event dropped, ovf<=1.
- Push and pop in the same cycle while full: accepted, count unchanged.
- Push and pop in the same cycle while empty: no bypass; the event is stored.
- ovf: clear_ovf takes priority over a simultaneous set.

## Timing
- Reset values: FSM=IDLE, skip counter=0, edge register=0, FIFO empty, ev_valid=0, ev_code=0, ev_ext=0, ev_release=0, ev_is_digit=0, ev_digit=0, ovf=0.
- Latency: rx_valid rises in cycle n (final byte) -> event registered in n+1 -> ev_valid=1 and head fields valid in n+2 (FIFO empty case).
- Head fields are stable while ev_valid=1 and ev_ready=0. The next entry appears the cycle after a pop.
- Assertion of reset at any point, including mid-sequence, returns to IDLE and empties the FIFO. A partial prefix is lost.
- Bytes arrive at most every ~1 ms at PS/2 rates, so no input backpressure exists. FIFO overflow is the only loss mechanism.

## Structure
- Package ps2_kbd_pkg holds:
  - prefix constants E0/F0/E1;
  - Pause skip length (7);
  - FSM state typedef;
  - event struct {code, ext, release, is_digit, digit} (15 bits).
- Sub-module ps2_event_fifo: generic synchronous FIFO of the event width with parameter FIFO_DEPTH, registered outputs, full/empty from a count of log2(depth)+1 bits. The decoder instantiates one.

## Test plan
- Make/break: send 1C, then F0 1C -> two events: {1C, ext0, rel0} then {1C, ext0, rel1}. First ev_valid exactly 2 cycles after the 1C strobe rises.
- Extended: send E0 75, then E0 F0 75 -> {75, ext1, rel0}, {75, ext1, rel1}. No digit flag on either.
- Digits: send 45 16 46 with ev_ready=1 -> is_digit=1 with digits 0, 1, 9. Send E0 45 -> is_digit=0.
- Pause: send E1 14 77 E1 F0 14 F0 77, then 1C -> exactly one event {1C}.
- Overflow: ev_ready=0, send 5 makes -> 4 buffered, ovf=1. Drain -> first 4 codes in order. Pulse clear_ovf -> ovf=0.
- Reset mid-sequence: send E0, assert reset, release, send 74 -> {74, ext0}. Hold rx_valid high 10 cycles -> one event only.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan-code decoder:
// prefix bytes, Pause swallow length, prefix FSM states and the key-event record.
package ps2_kbd_pkg;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  // Bytes that follow E1 in the 8-byte Pause sequence.
  localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } prefix_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       is_digit;
    logic [3:0] digit;
  } ps2_event_t;

  localparam int EVENT_W = $bits(ps2_event_t);

  // Number-row digit map for non-extended codes; returns {is_digit, digit}.
  function automatic logic [4:0] digit_lookup(input logic [7:0] code);
    case (code)
      8'h45:   return {1'b1, 4'd0};
      8'h16:   return {1'b1, 4'd1};
      8'h1E:   return {1'b1, 4'd2};
      8'h26:   return {1'b1, 4'd3};
      8'h25:   return {1'b1, 4'd4};
      8'h2E:   return {1'b1, 4'd5};
      8'h36:   return {1'b1, 4'd6};
      8'h3D:   return {1'b1, 4'd7};
      8'h3E:   return {1'b1, 4'd8};
      8'h46:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO with a registered head (o_valid/o_data) and count-based full/empty.
// A push while full is dropped unless a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int WIDTH      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_head_from_wr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == FULL_CNT);
  assign w_do_pop     = i_pop && !w_empty;
  assign w_do_push    = i_push && (!w_full || w_do_pop);
  assign o_drop       = i_push && !w_do_push;
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_do_pop);
  assign w_count_nxt  = r_count + CW'(w_do_push) - CW'(w_do_pop);

  // The incoming word becomes the head when nothing else remains after this cycle's pop.
  assign w_head_from_wr = w_do_push && (w_empty || (r_count == CW'(1) && w_do_pop));

  // NOTE: storage has no reset; entries are only read once written, and
  // leaving it out keeps the array in plain flops/RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      if (w_count_nxt == '0) begin
        r_data <= '0;
      end else if (w_head_from_wr) begin
        r_data <= i_data;
      end else begin
        r_data <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0/E1 prefixes into single key events,
// tags number-row digits and queues events for a valid/ready consumer.
module ps2_scancode_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       ev_ready,
  input  logic       clear_ovf,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       ev_is_digit,
  output logic [3:0] ev_digit,
  output logic       ovf
);

  logic          r_rx_valid;
  logic          w_take;
  prefix_state_t r_state;
  prefix_state_t w_state_nxt;
  logic [2:0]    r_skip_cnt;
  logic [2:0]    w_skip_nxt;
  logic          w_emit;
  logic          w_ext;
  logic          w_rel;
  logic [4:0]    w_digit_info;
  ps2_event_t    w_event;
  ps2_event_t    r_event;
  logic          r_push;
  logic          w_drop;
  logic          r_ovf;
  logic          w_head_valid;
  ps2_event_t    w_head;

  // A held strobe yields one byte: only the low-to-high transition is taken.
  assign w_take = rx_valid && !r_rx_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_valid <= 1'b0;
      r_state    <= ST_IDLE;
      r_skip_cnt <= '0;
    end else begin
      r_rx_valid <= rx_valid;
      r_state    <= w_state_nxt;
      r_skip_cnt <= w_skip_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    w_emit      = 1'b0;
    w_ext       = 1'b0;
    w_rel       = 1'b0;
    if (w_take) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == PFX_E0) begin
            w_state_nxt = ST_EXT;
          end else if (rx_data == PFX_F0) begin
            w_state_nxt = ST_BRK;
          end else if (rx_data == PFX_E1) begin
            w_state_nxt = ST_SKIP;
            w_skip_nxt  = PAUSE_SKIP_LEN;
          end else begin
            w_emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == PFX_F0) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (rx_data != PFX_E0) begin
            w_emit      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_state_nxt = ST_IDLE;
          if (rx_data != PFX_E0 && rx_data != PFX_F0) begin
            w_emit = 1'b1;
            w_rel  = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          if (rx_data != PFX_E0 && rx_data != PFX_F0) begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_rel  = 1'b1;
          end
        end
        ST_SKIP: begin
          if (r_skip_cnt <= 3'd1) begin
            w_skip_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_skip_nxt = r_skip_cnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_skip_nxt  = '0;
        end
      endcase
    end
  end

  // Digit tagging applies to plain (non-extended) codes only, make or break.
  always_comb begin
    w_digit_info     = digit_lookup(rx_data);
    w_event          = '0;
    w_event.code     = rx_data;
    w_event.ext      = w_ext;
    w_event.rel      = w_rel;
    w_event.is_digit = !w_ext && w_digit_info[4];
    w_event.digit    = w_ext ? 4'd0 : w_digit_info[3:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_push  <= 1'b0;
      r_event <= '0;
    end else begin
      r_push <= w_emit;
      if (w_emit) begin
        r_event <= w_event;
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH      (EVENT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_push),
    .i_data  (r_event),
    .i_pop   (ev_ready),
    .o_valid (w_head_valid),
    .o_data  (w_head),
    .o_drop  (w_drop)
  );

  // Clearing wins over a drop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign ev_valid    = w_head_valid;
  assign ev_code     = w_head.code;
  assign ev_ext      = w_head.ext;
  assign ev_release  = w_head.rel;
  assign ev_is_digit = w_head.is_digit;
  assign ev_digit    = w_head.digit;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a vector table of prefix/digit cases
// plus hand-written latency, Pause, overflow, reset and held-strobe sequences.
module tb_ps2_scancode_decoder;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_valid  = 1'b0;
  logic       ev_ready  = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic       ev_is_digit;
  logic [3:0] ev_digit;
  logic       ovf;

  int passed = 0;
  int total  = 0;
  int n_pops = 0;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .ev_ready    (ev_ready),
    .clear_ovf   (clear_ovf),
    .ev_valid    (ev_valid),
    .ev_code     (ev_code),
    .ev_ext      (ev_ext),
    .ev_release  (ev_release),
    .ev_is_digit (ev_is_digit),
    .ev_digit    (ev_digit),
    .ovf         (ovf)
  );

  always @(posedge clk) begin
    if (ev_valid && ev_ready) n_pops <= n_pops + 1;
  end

  typedef struct {
    logic [31:0] bytes;
    int          nb;
    logic [7:0]  code;
    logic        ext;
    logic        rel;
    logic        is_digit;
    logic [3:0]  digit;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_event(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ev_valid;
    end
    check({name, "_seen"}, seen, 1);
  endtask

  task automatic check_head(input string name, input logic [7:0] code, input logic ext,
                            input logic rel, input logic isd, input logic [3:0] dig);
    check({name, "_code"}, ev_code, code);
    check({name, "_ext"}, ev_ext, ext);
    check({name, "_rel"}, ev_release, rel);
    check({name, "_isdig"}, ev_is_digit, isd);
    check({name, "_digit"}, ev_digit, dig);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pause_seq [8];
    logic [7:0] drain_exp [4];
    int p0;

    vecs[0]  = '{32'hF01C0000, 2, 8'h1C, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[1]  = '{32'hE0750000, 2, 8'h75, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{32'hE0F07500, 3, 8'h75, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[3]  = '{32'h45000000, 1, 8'h45, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[4]  = '{32'h16000000, 1, 8'h16, 1'b0, 1'b0, 1'b1, 4'd1};
    vecs[5]  = '{32'h46000000, 1, 8'h46, 1'b0, 1'b0, 1'b1, 4'd9};
    vecs[6]  = '{32'hE0450000, 2, 8'h45, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[7]  = '{32'hF03D0000, 2, 8'h3D, 1'b0, 1'b1, 1'b1, 4'd7};
    vecs[8]  = '{32'hE0E06B00, 3, 8'h6B, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[9]  = '{32'hF0F01C00, 3, 8'h1C, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[10] = '{32'hE0F0E074, 4, 8'h74, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[11] = '{32'h3E000000, 1, 8'h3E, 1'b0, 1'b0, 1'b1, 4'd8};
    vecs[12] = '{32'h2E000000, 1, 8'h2E, 1'b0, 1'b0, 1'b1, 4'd5};
    vecs[13] = '{32'h36000000, 1, 8'h36, 1'b0, 1'b0, 1'b1, 4'd6};
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    drain_exp = '{8'h1E, 8'h26, 8'h25, 8'h3D};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", ev_valid, 0);
    check_head("rst", 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    check("rst_ovf", ovf, 0);
    reset = 1'b1;
    @(negedge clk);

    // Make with exact two-cycle latency
    rx_data  = 8'h1C;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("lat_n1_valid", ev_valid, 0);
    @(negedge clk);
    check("lat_n2_valid", ev_valid, 1);
    check_head("make", 8'h1C, 1'b0, 1'b0, 1'b0, 4'd0);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    check("make_popped", ev_valid, 0);

    // Table of single-event sequences, consumer always ready
    ev_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      for (int b = 0; b < vecs[i].nb; b++) send_byte(vecs[i].bytes[31-8*b -: 8]);
      wait_event($sformatf("v%0d", i));
      check_head($sformatf("v%0d", i), vecs[i].code, vecs[i].ext, vecs[i].rel,
                 vecs[i].is_digit, vecs[i].digit);
      @(negedge clk);
      check($sformatf("v%0d_drained", i), ev_valid, 0);
    end

    // Pause sequence is swallowed; the following make comes through alone
    p0 = n_pops;
    for (int k = 0; k < 8; k++) send_byte(pause_seq[k]);
    repeat (4) @(negedge clk);
    check("pause_no_event", n_pops - p0, 0);
    send_byte(8'h1C);
    wait_event("after_pause");
    check_head("after_pause", 8'h1C, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    check("after_pause_count", n_pops - p0, 1);

    // Overflow: fill four, fifth is dropped
    ev_ready = 1'b0;
    send_byte(8'h16);
    send_byte(8'h1E);
    send_byte(8'h26);
    send_byte(8'h25);
    repeat (3) @(negedge clk);
    check("full_ovf_clear", ovf, 0);
    check("full_head", ev_code, 8'h16);
    send_byte(8'h2E);
    repeat (3) @(negedge clk);
    check("ovf_set", ovf, 1);
    check("ovf_head_stable", ev_code, 8'h16);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Push and pop in the same cycle while full: accepted, no drop
    rx_data  = 8'h3D;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    check("pushpop_full_ovf", ovf, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_valid", k), ev_valid, 1);
      check($sformatf("drain%0d_code", k), ev_code, drain_exp[k]);
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
    end
    check("drain_empty", ev_valid, 0);

    // Reset mid-sequence loses the prefix and the buffered event
    send_byte(8'h1C);
    send_byte(8'hE0);
    check("pre_rst_buffered", ev_valid, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("in_rst_valid", ev_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_code", ev_code, 8'h00);
    send_byte(8'h74);
    wait_event("post_rst");
    check_head("post_rst", 8'h74, 1'b0, 1'b0, 1'b0, 4'd0);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    check("post_rst_popped", ev_valid, 0);

    // Strobe held for ten cycles gives one event
    rx_data  = 8'h1C;
    rx_valid = 1'b1;
    repeat (10) @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_valid", ev_valid, 1);
    check("hold_code", ev_code, 8'h1C);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    check("hold_single", ev_valid, 0);
    repeat (3) @(negedge clk);
    check("hold_still_empty", ev_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
